// File: rtl/uc_secuenciador.sv
// Sequenced control unit: opcode decode plus RUN/HALTED/ERROR sequencing with step and trap.
// Optional executed-instruction counter built only when UC_INSTR_CNT_EN is defined.
module uc_secuenciador #(
   parameter int START_RUN = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   input  logic             run,
   input  logic             step,
   input  logic             clear_err,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             pc_en,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_RUN,
      S_HALTED,
      S_ERROR
   } state_t;

   typedef enum logic [2:0] {
      C_ALU  = 3'b000,
      C_LI   = 3'b001,
      C_J    = 3'b010,
      C_JZ   = 3'b011,
      C_JNZ  = 3'b100,
      C_NOP  = 3'b101,
      C_HALT = 3'b110,
      C_ILL  = 3'b111
   } iclass_t;

   localparam state_t RESET_STATE = (START_RUN != 0) ? S_RUN : S_HALTED;

   state_t     state;
   state_t     state_n;
   logic       run_d;
   logic       step_d;
   logic       run_edge;
   logic       step_edge;
   logic       legal;
   logic       is_halt;
   logic       exec;
   iclass_t    cls;

   logic       d_s_inc;
   logic       d_s_inm;
   logic       d_we3;
   logic       d_wez;
   logic [2:0] d_op;

   assign cls       = iclass_t'(Opcode[5:3]);
   assign legal     = (cls != C_ILL);
   assign is_halt   = (cls == C_HALT);
   assign run_edge  = run & ~run_d;
   assign step_edge = step & ~step_d;

   // A step edge arriving with a run edge is dropped; the run edge only resumes.
   assign exec = legal &
                 (((state == S_RUN) && run) ||
                  ((state == S_HALTED) && step_edge && !run_edge));

   // Pure opcode decode, independent of sequencing state.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      d_s_inc = 1'b1;
      d_s_inm = 1'b0;
      d_we3   = 1'b0;
      d_wez   = 1'b0;
      d_op    = 3'b000;
      case (cls)
         C_ALU: begin
            d_op  = Opcode[2:0];
            d_we3 = 1'b1;
            d_wez = 1'b1;
         end
         C_LI: begin
            d_s_inm = 1'b1;
            d_we3   = 1'b1;
         end
         C_J:     d_s_inc = 1'b0;
         C_JZ:    d_s_inc = ~z;
         C_JNZ:   d_s_inc = z;
         default: d_s_inc = 1'b1;
      endcase
   end

   // State register and edge-detector history.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state  <= RESET_STATE;
         run_d  <= 1'b1;
         step_d <= 1'b1;
      end else begin
         state  <= state_n;
         run_d  <= run;
         step_d <= step;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_RUN: begin
            if (!run)
               state_n = S_HALTED;
            else if (!legal)
               state_n = S_ERROR;
            else if (is_halt)
               state_n = S_HALTED;
         end
         S_HALTED: begin
            if (run_edge)
               state_n = S_RUN;
            else if (step_edge && !legal)
               state_n = S_ERROR;
         end
         S_ERROR: begin
            if (clear_err)
               state_n = S_HALTED;
         end
         default: state_n = RESET_STATE;
      endcase
   end

   // Steering lines always show the decode; only the write/PC enables are gated.
   always_comb begin
      s_inc  = d_s_inc;
      s_inm  = d_s_inm;
      Op     = d_op;
      we3    = exec & d_we3;
      wez    = exec & d_wez;
      pc_en  = exec;
      halted = (state == S_HALTED);
      err    = (state == S_ERROR);
   end

`ifdef UC_INSTR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q;

   // Saturating count of executed instructions.
   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else if (exec && (count_q != '1))
         count_q <= count_q + CNT_ONE;
   end

   assign instr_count = count_q;
`else
   assign instr_count = '0;
`endif

endmodule
